// File: rtl/iss_step_seq_pkg.sv
// iss_step_seq_pkg: shared types for the ISS lock-step sequencer.
// Entries are stored at a fixed maximal width; narrower lanes zero-extend.
package iss_step_seq_pkg;

   localparam int unsigned ENT_XLEN = 64;
   localparam int unsigned ENT_ILEN = 32;

   localparam int unsigned FLD_PC    = 0;
   localparam int unsigned FLD_INSN  = 1;
   localparam int unsigned FLD_RD    = 2;
   localparam int unsigned FLD_WDATA = 3;
   localparam int unsigned FLD_TRAP  = 4;
   localparam int unsigned FLD_W     = 5;

   typedef enum logic [1:0] {
      IDLE,
      MIP,
      STEP
   } state_e;

   typedef struct packed {
      logic [ENT_XLEN-1:0] pc;
      logic [ENT_ILEN-1:0] insn;
      logic [4:0]          rd_addr;
      logic [ENT_XLEN-1:0] rd_wdata;
      logic                trap;
   } entry_t;

   // rd_wdata only matters when the core actually wrote a register
   function automatic logic [FLD_W-1:0] cmp_fields(entry_t c, entry_t m);
      logic [FLD_W-1:0] f;
      f            = '0;
      f[FLD_PC]    = (c.pc != m.pc);
      f[FLD_INSN]  = (c.insn != m.insn);
      f[FLD_RD]    = (c.rd_addr != m.rd_addr);
      f[FLD_WDATA] = (c.rd_addr != 5'd0) && (c.rd_wdata != m.rd_wdata);
      f[FLD_TRAP]  = (c.trap != m.trap);
      return f;
   endfunction

endpackage

// File: rtl/iss_step_sequencer_if.sv
// iss_step_sequencer_if: step handshake and mip injection toward the ISS.
// master = sequencer side, slave = reference model side.
interface iss_step_sequencer_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ILEN = 32
);

   logic            ref_step_req_o;
   logic            ref_step_ack_i;
   logic [XLEN-1:0] ref_pc_i;
   logic [ILEN-1:0] ref_insn_i;
   logic [4:0]      ref_rd_addr_i;
   logic [XLEN-1:0] ref_rd_wdata_i;
   logic            ref_trap_i;
   logic            ref_mip_valid_o;
   logic [31:0]     ref_mip_o;

   modport master (
      output ref_step_req_o,
      output ref_mip_valid_o,
      output ref_mip_o,
      input  ref_step_ack_i,
      input  ref_pc_i,
      input  ref_insn_i,
      input  ref_rd_addr_i,
      input  ref_rd_wdata_i,
      input  ref_trap_i
   );

   modport slave (
      input  ref_step_req_o,
      input  ref_mip_valid_o,
      input  ref_mip_o,
      output ref_step_ack_i,
      output ref_pc_i,
      output ref_insn_i,
      output ref_rd_addr_i,
      output ref_rd_wdata_i,
      output ref_trap_i
   );

endinterface

// File: rtl/rvfi_multi_port_fifo.sv
// rvfi_multi_port_fifo: NRET compacting write ports, one read port.
// Free space is taken before the pop, so a popped slot is never refilled same cycle.
module rvfi_multi_port_fifo
   import iss_step_seq_pkg::*;
#(
   parameter int unsigned NRET  = 2,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NRET-1:0]            i_valid,
   input  entry_t                     i_entry [NRET],
   input  logic                       i_pop,
   output entry_t                     o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_drop
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_free;
   logic [CW-1:0]   w_nwr;
   logic [NRET-1:0] w_we;
   logic [PW-1:0]   w_waddr [NRET];
   logic            w_drop;

   always_comb begin
      w_free = CW'(DEPTH) - r_count;
      w_nwr  = '0;
      w_we   = '0;
      w_drop = 1'b0;
      for (int l = 0; l < NRET; l++) begin
         w_waddr[l] = r_wptr + PW'(w_nwr);
         if (i_valid[l]) begin
            if (w_nwr < w_free) begin
               w_we[l] = 1'b1;
               w_nwr   = w_nwr + CW'(1);
            end else begin
               w_drop = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int l = 0; l < NRET; l++) begin
         if (w_we[l]) begin
            r_mem[w_waddr[l]] <= i_entry[l];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + PW'(w_nwr);
         r_count <= r_count + w_nwr - CW'(i_pop);
         if (i_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_drop  = w_drop;

endmodule

// File: rtl/iss_step_sequencer.sv
// iss_step_sequencer: steps an external ISS one retirement at a time
// and compares each result against the buffered core RVFI record.
module iss_step_sequencer
   import iss_step_seq_pkg::*;
#(
   parameter int unsigned NRET  = 2,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned ILEN  = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NRET-1:0]        core_valid_i,
   input  logic [NRET*XLEN-1:0]   core_pc_i,
   input  logic [NRET*ILEN-1:0]   core_insn_i,
   input  logic [NRET*5-1:0]      core_rd_addr_i,
   input  logic [NRET*XLEN-1:0]   core_rd_wdata_i,
   input  logic [NRET-1:0]        core_trap_i,
   input  logic                   irq_valid_i,
   input  logic [31:0]            irq_mip_i,
   iss_step_sequencer_if.master   ref_if,
   output logic                   mismatch_o,
   output logic [FLD_W-1:0]       mismatch_field_o,
   output logic [15:0]            mismatch_count_o,
   output logic [31:0]            retired_count_o,
   output logic                   overflow_o,
   output logic                   idle_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   state_e           r_state;
   state_e           w_state_nxt;
   entry_t           w_lane [NRET];
   entry_t           w_head;
   entry_t           w_ref;
   logic [CW-1:0]    w_count;
   logic             w_drop;
   logic             w_pop;
   logic             w_req;
   logic             w_mipv;
   logic             w_mip_clr;
   logic [FLD_W-1:0] w_fld;

   logic             r_mip_pend;
   logic [31:0]      r_mip_val;
   logic             r_mm;
   logic [FLD_W-1:0] r_fld;
   logic [15:0]      r_mcnt;
   logic [31:0]      r_ret;
   logic             r_ovf;

   always_comb begin
      for (int l = 0; l < NRET; l++) begin
         w_lane[l].pc       = ENT_XLEN'(core_pc_i[l*XLEN +: XLEN]);
         w_lane[l].insn     = ENT_ILEN'(core_insn_i[l*ILEN +: ILEN]);
         w_lane[l].rd_addr  = core_rd_addr_i[l*5 +: 5];
         w_lane[l].rd_wdata = ENT_XLEN'(core_rd_wdata_i[l*XLEN +: XLEN]);
         w_lane[l].trap     = core_trap_i[l];
      end
   end

   always_comb begin
      w_ref.pc       = ENT_XLEN'(ref_if.ref_pc_i);
      w_ref.insn     = ENT_ILEN'(ref_if.ref_insn_i);
      w_ref.rd_addr  = ref_if.ref_rd_addr_i;
      w_ref.rd_wdata = ENT_XLEN'(ref_if.ref_rd_wdata_i);
      w_ref.trap     = ref_if.ref_trap_i;
   end

   rvfi_multi_port_fifo #(
      .NRET  (NRET),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_valid (core_valid_i),
      .i_entry (w_lane),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_drop  (w_drop)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // mip is only injected from IDLE, so it always lands between steps
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_mipv      = 1'b0;
      w_mip_clr   = 1'b0;
      w_pop       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (r_mip_pend) begin
               w_state_nxt = MIP;
            end else if (w_count != '0) begin
               w_state_nxt = STEP;
            end
         end
         MIP: begin
            w_mipv      = 1'b1;
            w_mip_clr   = 1'b1;
            w_state_nxt = IDLE;
         end
         STEP: begin
            w_req = 1'b1;
            if (ref_if.ref_step_ack_i) begin
               w_pop       = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mip_pend <= 1'b0;
         r_mip_val  <= '0;
      end else if (irq_valid_i) begin
         r_mip_pend <= 1'b1;
         r_mip_val  <= irq_mip_i;
      end else if (w_mip_clr) begin
         r_mip_pend <= 1'b0;
      end
   end

   assign w_fld = cmp_fields(w_head, w_ref);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mm   <= 1'b0;
         r_fld  <= '0;
         r_mcnt <= '0;
         r_ret  <= '0;
         r_ovf  <= 1'b0;
      end else begin
         r_mm  <= w_pop && (w_fld != '0);
         r_ovf <= r_ovf | w_drop;
         if (w_pop) begin
            r_fld <= w_fld;
            r_ret <= r_ret + 32'd1;
            if ((w_fld != '0) && (r_mcnt != 16'hFFFF)) begin
               r_mcnt <= r_mcnt + 16'd1;
            end
         end
      end
   end

   assign ref_if.ref_step_req_o  = w_req;
   assign ref_if.ref_mip_valid_o = w_mipv;
   assign ref_if.ref_mip_o       = w_mipv ? r_mip_val : 32'd0;

   assign mismatch_o       = r_mm;
   assign mismatch_field_o = r_fld;
   assign mismatch_count_o = r_mcnt;
   assign retired_count_o  = r_ret;
   assign overflow_o       = r_ovf;
   assign idle_o           = (r_state == IDLE) && (w_count == '0)
                             && !r_mip_pend;

endmodule

// File: tb/tb_iss_step_sequencer.sv
// tb_iss_step_sequencer: random retirements and ISS responses checked
// against a queue-based model of the lock-step rules.
module tb_iss_step_sequencer;

   localparam int NRET  = 2;
   localparam int DEPTH = 8;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        trap;
   } rec_t;

   logic              clk;
   logic              rst_ni;
   logic [NRET-1:0]   core_valid;
   logic [NRET*32-1:0] core_pc;
   logic [NRET*32-1:0] core_insn;
   logic [NRET*5-1:0]  core_rd;
   logic [NRET*32-1:0] core_wd;
   logic [NRET-1:0]   core_trap;
   logic              irq_valid;
   logic [31:0]       irq_mip;
   logic              mismatch;
   logic [4:0]        mm_field;
   logic [15:0]       mm_count;
   logic [31:0]       ret_count;
   logic              overflow;
   logic              idle;

   iss_step_sequencer_if #(.XLEN(32), .ILEN(32)) rif ();

   iss_step_sequencer #(
      .NRET(NRET), .DEPTH(DEPTH), .XLEN(32), .ILEN(32)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .core_valid_i     (core_valid),
      .core_pc_i        (core_pc),
      .core_insn_i      (core_insn),
      .core_rd_addr_i   (core_rd),
      .core_rd_wdata_i  (core_wd),
      .core_trap_i      (core_trap),
      .irq_valid_i      (irq_valid),
      .irq_mip_i        (irq_mip),
      .ref_if           (rif),
      .mismatch_o       (mismatch),
      .mismatch_field_o (mm_field),
      .mismatch_count_o (mm_count),
      .retired_count_o  (ret_count),
      .overflow_o       (overflow),
      .idle_o           (idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   rec_t        q[$];
   logic        e_mm, e_ovf;
   logic [4:0]  e_fld;
   logic [15:0] e_mcnt;
   logic [31:0] e_ret;
   logic        pend, pend_last, req_prev;
   logic [31:0] pend_val;

   task automatic model_reset();
      q.delete();
      e_mm = 0; e_ovf = 0; e_fld = 0; e_mcnt = 0; e_ret = 0;
      pend = 0; pend_last = 0; req_prev = 0; pend_val = 0;
   endtask

   task automatic drive_idle();
      core_valid = '0; core_pc = '0; core_insn = '0; core_rd = '0;
      core_wd = '0; core_trap = '0; irq_valid = 0; irq_mip = '0;
      rif.ref_step_ack_i = 0; rif.ref_pc_i = '0; rif.ref_insn_i = '0;
      rif.ref_rd_addr_i = '0; rif.ref_rd_wdata_i = '0; rif.ref_trap_i = 0;
   endtask

   task automatic step_cycle(int p_valid, int p_ack, int p_irq);
      rec_t        lanes [NRET];
      rec_t        h, r;
      logic        req, mipv, ack;
      logic [4:0]  f;
      int          free;
      @(negedge clk);
      req  = rif.ref_step_req_o;
      mipv = rif.ref_mip_valid_o;
      chk("mm_pulse", mismatch, e_mm);
      chk("mm_field", mm_field, e_fld);
      chk("mm_count", mm_count, e_mcnt);
      chk("ret_count", ret_count, e_ret);
      chk("overflow", overflow, e_ovf);
      chk("idle", idle, !req && !mipv && q.size() == 0 && !pend);
      chk("mip_in_step", mipv && req, 0);
      if (mipv) begin
         chk("mip_pend", pend, 1);
         chk("mip_val", rif.ref_mip_o, pend_val);
      end
      if (req) chk("req_empty", q.size() != 0, 1);
      if (req && !req_prev) chk("step_before_mip", pend_last, 0);
      pend_last = pend;
      for (int l = 0; l < NRET; l++) begin
         lanes[l].pc   = $urandom & 32'hFFFF_FFFC;
         lanes[l].insn = $urandom;
         lanes[l].rd   = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
         lanes[l].wd   = $urandom;
         lanes[l].trap = ($urandom_range(9) == 0);
         core_valid[l] = ($urandom_range(99) < p_valid);
         core_pc[l*32 +: 32]   = lanes[l].pc;
         core_insn[l*32 +: 32] = lanes[l].insn;
         core_rd[l*5 +: 5]     = lanes[l].rd;
         core_wd[l*32 +: 32]   = lanes[l].wd;
         core_trap[l]          = lanes[l].trap;
      end
      irq_valid = ($urandom_range(99) < p_irq);
      irq_mip   = $urandom;
      ack = req && (q.size() != 0) && ($urandom_range(99) < p_ack);
      if (ack) begin
         r = q[0];
         f = ($urandom_range(9) < 3) ? 5'($urandom_range(1, 31)) : 5'd0;
         if (f[0]) r.pc   = r.pc ^ 32'h4;
         if (f[1]) r.insn = r.insn ^ 32'h1;
         if (f[2]) r.rd   = r.rd ^ 5'h1;
         if (f[3]) r.wd   = r.wd ^ 32'h10;
         if (f[4]) r.trap = ~r.trap;
      end else begin
         r.pc = $urandom; r.insn = $urandom; r.rd = 5'($urandom);
         r.wd = $urandom; r.trap = 1'($urandom);
      end
      rif.ref_step_ack_i = ack;
      rif.ref_pc_i       = r.pc;
      rif.ref_insn_i     = r.insn;
      rif.ref_rd_addr_i  = r.rd;
      rif.ref_rd_wdata_i = r.wd;
      rif.ref_trap_i     = r.trap;
      free = DEPTH - q.size();
      e_mm = 0;
      if (ack) begin
         h = q.pop_front();
         f = '0;
         f[0] = h.pc != r.pc;
         f[1] = h.insn != r.insn;
         f[2] = h.rd != r.rd;
         f[3] = (h.rd != 0) && (h.wd != r.wd);
         f[4] = h.trap != r.trap;
         e_mm  = (f != 0);
         e_fld = f;
         e_ret = e_ret + 1;
         if (f != 0 && e_mcnt != 16'hFFFF) e_mcnt = e_mcnt + 1;
      end
      for (int l = 0; l < NRET; l++) begin
         if (core_valid[l]) begin
            if (free > 0) begin
               q.push_back(lanes[l]);
               free--;
            end else begin
               e_ovf = 1;
            end
         end
      end
      if (irq_valid) begin
         pend = 1;
         pend_val = irq_mip;
      end else if (mipv) begin
         pend = 0;
      end
      req_prev = req;
   endtask

   initial begin
      bit hit;
      rst_ni = 1'b0;
      drive_idle();
      model_reset();
      #3;
      chk("rst_req", rif.ref_step_req_o, 0);
      chk("rst_mipv", rif.ref_mip_valid_o, 0);
      chk("rst_idle", idle, 1);
      chk("rst_ret", ret_count, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk);
      rst_ni = 1'b1;

      repeat (600) step_cycle(30, 50, 5);
      repeat (300) step_cycle(90, 5, 5);

      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         step_cycle(0, 0, 0);
         hit = req_prev;
      end
      chk("rst_wait_step", hit, 1);
      #1;
      rst_ni = 1'b0;
      drive_idle();
      #1;
      chk("mid_rst_req", rif.ref_step_req_o, 0);
      chk("mid_rst_idle", idle, 1);
      chk("mid_rst_ret", ret_count, 0);
      chk("mid_rst_mcnt", mm_count, 0);
      chk("mid_rst_ovf", overflow, 0);
      chk("mid_rst_mm", mismatch, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;

      repeat (600) step_cycle(20, 70, 15);
      repeat (200) step_cycle(0, 60, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/iss_step_sequencer.md
# iss_step_sequencer

Synthesizable lock-step sequencer between a core's multi-retire RVFI trace and an external ISS reference model. It buffers up to NRET retirements per cycle in order, steps the reference model one instruction at a time over a req/ack handshake, and compares each result against the buffered core record. It injects pending interrupt state (mip) only between steps, and reports mismatches, overflow and progress counters to the bench.

## Interface
Parameters:
- NRET, 2: retirement lanes per cycle, lane 0 oldest.
- DEPTH, 8: buffer entries, power of two, at least NRET.
- XLEN, 32: data/pc width.
- ILEN, 32: instruction width.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- core_valid_i  in  NRET  per-lane retirement valid.
- core_pc_i  in  NRET*XLEN  pc per lane.
- core_insn_i  in  NRET*ILEN  instruction per lane.
- core_rd_addr_i  in  NRET*5  destination register per lane.
- core_rd_wdata_i  in  NRET*XLEN  write data per lane.
- core_trap_i  in  NRET  trap flag per lane.
- irq_valid_i  in  1  one-cycle request to update mip.
- irq_mip_i  in  32  mip value for that request.
- ref_step_req_o  out  1  step request to the reference model.
- ref_step_ack_i  in  1  reference result valid; sampled only while req=1.
- ref_pc_i, ref_insn_i, ref_rd_addr_i, ref_rd_wdata_i, ref_trap_i  in  XLEN/ILEN/5/XLEN/1  reference result.
- ref_mip_valid_o  out  1  one-cycle mip write pulse; no instruction is stepped.
- ref_mip_o  out  32  mip value, valid with the pulse.
- mismatch_o  out  1  one-cycle pulse per failing compare.
- mismatch_field_o  out  5  failing fields {trap, rd_wdata, rd_addr, insn, pc}; holds until the next compare.
- mismatch_count_o  out  16  saturating count of failing compares.
- retired_count_o  out  32  count of completed compares; wraps.
- overflow_o  out  1  sticky: at least one retirement was dropped.
- idle_o  out  1  FSM in IDLE, buffer empty, no mip pending.

## Operation
- Enqueue: each cycle, valid lanes are compacted in lane order and written while free slots remain. Lanes beyond the free space are dropped and overflow_o is set; it stays set until reset.
- Pending mip: irq_valid_i loads a pending register and sets a pending flag. A later request overwrites the value; the pending count does not increment.
- The FSM has three states: IDLE, MIP and STEP.
- IDLE: if mip is pending, go to MIP. Otherwise, if the buffer is non-empty, go to STEP. Otherwise stay in IDLE.
- MIP (one cycle): ref_mip_valid_o=1 and ref_mip_o=pending value. The pending flag clears, unless irq_valid_i is asserted in the same cycle; in that case the new value stays pending. Next state is IDLE.
- STEP: ref_step_req_o=1 is held until ref_step_ack_i. On ack, the head entry is compared with the ref_* inputs and popped, and the next state is IDLE.
  - rd_wdata is compared only if the core rd_addr is not 0.
  - rd_addr, pc, insn and trap are always compared.
- mip is never applied while in STEP; irq_valid_i arriving during STEP waits.
- Counters: mismatch_count_o saturates at 16'hFFFF; retired_count_o wraps modulo 2^32.
- Reset at any point (including mid-STEP):
  - buffer empties, pending flag clears, FSM returns to IDLE;
  - all outputs go to 0, except idle_o=1.

## Timing
- Entries enqueued at edge e are visible in IDLE at cycle e+1. STEP is entered at e+2.
- Ack may arrive in the first STEP cycle. Minimum step period is 2 cycles (IDLE, STEP).
- mismatch_o, mismatch_field_o and the counters update at the edge that samples ack; they are visible the cycle after ack.
- A simultaneous enqueue and pop in the ack cycle is legal. Free space for that cycle's enqueue is computed before the pop, so no slot is reused in the same cycle.
- The buffer is full at count==DEPTH. Read and write pointers wrap modulo DEPTH.

## Structure
- Package iss_step_seq_pkg holds:
  - state enum {IDLE, MIP, STEP};
  - entry struct (pc, insn, rd_addr, rd_wdata, trap);
  - localparams for mismatch_field_o bit indices.
- Sub-module rvfi_multi_port_fifo: NRET write ports with lane compaction, 1 read port, count output, drop flag.

## Test plan
- Single-lane sequence at pc 0x80, 0x84, 0x88 with the reference model echoing matching results → 3 req/ack steps, retired_count_o=3, mismatch_o never asserted.
- Both lanes valid in one cycle (pc 0x80, 0x84) → reference steps in order 0x80 then 0x84.
- Reference returns rd_wdata 0x5 against core 0x6 with rd_addr=3 → mismatch_field_o=5'b01000 and mismatch_count_o=1. The same difference with rd_addr=0 → no mismatch.
- irq_valid_i with mip=0x800 while in STEP with ack delayed 4 cycles → no mip pulse during STEP; pulse with 0x800 after ack and before the next STEP. Two requests (0x8, then 0x800) before the pulse → a single pulse with 0x800.
- DEPTH=8, ack held low, 5 cycles of 2-lane retirement → first 8 entries kept, 2 dropped, overflow_o=1 and stays set.
- rst_ni low mid-STEP → ref_step_req_o drops immediately, idle_o=1, counters 0; a post-reset retirement steps normally.
